// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver. Reads have a registered one-cycle latency (o_Rd_DV pulse).
// There is no backpressure: a write to a full FIFO is dropped and latches o_Overflow, unless a read frees a slot in the same cycle.
module uart_rx_fifo #(
   parameter int DEPTH        = 16,
   parameter int ADDR_W       = 4,
   parameter int AFULL_THRESH = 12
) (
   input  logic              clk,
   input  logic              i_Rst,
   input  logic              i_DV,
   input  logic [7:0]        i_Byte,
   input  logic              i_Rd_En,
   input  logic              i_Ovf_Clr,
   output logic [7:0]        o_Byte,
   output logic              o_Rd_DV,
   output logic [ADDR_W:0]   o_Count,
   output logic              o_Empty,
   output logic              o_Full,
   output logic              o_AFull,
   output logic              o_Overflow
);
   localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_AFULL = (ADDR_W+1)'(AFULL_THRESH);
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

   logic [7:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [7:0]        byte_q, byte_d;
   logic              rd_dv_q, rd_dv_d;
   logic              ovf_q, ovf_d;
   logic              rd_acc, wr_acc;

   assign o_Empty    = (count_q == '0);
   assign o_Full     = (count_q == CNT_FULL);
   assign o_AFull    = (count_q >= CNT_AFULL);
   assign o_Count    = count_q;
   assign o_Byte     = byte_q;
   assign o_Rd_DV    = rd_dv_q;
   assign o_Overflow = ovf_q;

   // A read in the same cycle frees a slot, so a full FIFO can still accept a write.
   assign rd_acc = i_Rd_En && !o_Empty;
   assign wr_acc = i_DV && (!o_Full || rd_acc);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      byte_d   = byte_q;
      ovf_d    = ovf_q;
      rd_dv_d  = rd_acc;
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         byte_d   = mem_q[rd_ptr_q];
      end
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      if (i_DV && !wr_acc) begin
         ovf_d = 1'b1;
      end else if (i_Ovf_Clr) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (i_Rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         byte_q   <= '0;
         rd_dv_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         byte_q   <= byte_d;
         rd_dv_q  <= rd_dv_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is not reset; the non-blocking write means a same-address read sees the old entry.
   always_ff @(posedge clk) begin
      if (wr_acc && !i_Rst) begin
         mem_q[wr_ptr_q] <= i_Byte;
      end
   end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based model of the FIFO rules.
module tb_uart_rx_fifo;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       i_Rst = 1'b0, i_DV = 1'b0, i_Rd_En = 1'b0, i_Ovf_Clr = 1'b0;
   logic [7:0] i_Byte = 8'h00;
   logic [7:0] o_Byte;
   logic       o_Rd_DV, o_Empty, o_Full, o_AFull, o_Overflow;
   logic [4:0] o_Count;

   int nchk = 0;
   int nfail = 0;

   logic [7:0] q[$];
   logic [7:0] exp_byte = 8'h00;
   logic       exp_rd_dv = 1'b0;
   logic       exp_ovf = 1'b0;

   uart_rx_fifo #(.DEPTH(16), .ADDR_W(4), .AFULL_THRESH(12)) dut (
      .clk(clk), .i_Rst(i_Rst), .i_DV(i_DV), .i_Byte(i_Byte), .i_Rd_En(i_Rd_En),
      .i_Ovf_Clr(i_Ovf_Clr), .o_Byte(o_Byte), .o_Rd_DV(o_Rd_DV), .o_Count(o_Count),
      .o_Empty(o_Empty), .o_Full(o_Full), .o_AFull(o_AFull), .o_Overflow(o_Overflow)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, let the edge pass, then advance the reference model.
   task automatic step(input logic rst, input logic dv, input logic [7:0] b,
                       input logic rd, input logic clr);
      logic rd_ok, wr_ok;
      i_Rst = rst; i_DV = dv; i_Byte = b; i_Rd_En = rd; i_Ovf_Clr = clr;
      @(posedge clk);
      #1;
      if (rst) begin
         q.delete();
         exp_byte = 8'h00; exp_rd_dv = 1'b0; exp_ovf = 1'b0;
      end else begin
         rd_ok = rd && (q.size() > 0);
         wr_ok = dv && ((q.size() < DEPTH) || rd_ok);
         exp_rd_dv = rd_ok;
         if (rd_ok) exp_byte = q.pop_front();
         if (wr_ok) q.push_back(b);
         if (dv && !wr_ok) exp_ovf = 1'b1;
         else if (clr) exp_ovf = 1'b0;
      end
      i_Rst = 1'b0; i_DV = 1'b0; i_Byte = 8'h00; i_Rd_En = 1'b0; i_Ovf_Clr = 1'b0;
   endtask

   task automatic test_reset;
      step(1, 0, 8'h00, 0, 0);
      step(1, 0, 8'h00, 0, 0);
      nchk++; if (o_Count !== 5'd0) begin nfail++; $display("FAIL reset_count got=%0d exp=0", o_Count); end
      nchk++; if (o_Empty !== 1'b1) begin nfail++; $display("FAIL reset_empty got=%b exp=1", o_Empty); end
      nchk++; if (o_Full !== 1'b0 || o_AFull !== 1'b0) begin nfail++; $display("FAIL reset_full_afull got=%b%b exp=00", o_Full, o_AFull); end
      nchk++; if (o_Rd_DV !== 1'b0) begin nfail++; $display("FAIL reset_rddv got=%b exp=0", o_Rd_DV); end
      nchk++; if (o_Byte !== 8'h00) begin nfail++; $display("FAIL reset_byte got=%h exp=00", o_Byte); end
      nchk++; if (o_Overflow !== 1'b0) begin nfail++; $display("FAIL reset_ovf got=%b exp=0", o_Overflow); end
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 8'h00, 1, 0);
         nchk++; if (o_Rd_DV !== 1'b0 || o_Count !== 5'd0 || o_Byte !== 8'h00)
            begin nfail++; $display("FAIL empty_read rddv=%b cnt=%0d byte=%h exp 0/0/00", o_Rd_DV, o_Count, o_Byte); end
      end
   endtask

   task automatic test_basic;
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 8'h41 + 8'(i), 0, 0);
         step(0, 0, 8'h00, 0, 0);
      end
      nchk++; if (o_Count !== 5'd3) begin nfail++; $display("FAIL basic_count got=%0d exp=3", o_Count); end
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 8'h00, 1, 0);
         nchk++; if (o_Rd_DV !== 1'b1 || o_Byte !== 8'h41 + 8'(i))
            begin nfail++; $display("FAIL basic_read%0d rddv=%b byte=%h exp 1/%h", i, o_Rd_DV, o_Byte, 8'h41 + 8'(i)); end
         nchk++; if (o_Count !== 5'(2 - i)) begin nfail++; $display("FAIL basic_cnt%0d got=%0d exp=%0d", i, o_Count, 2 - i); end
      end
      step(0, 0, 8'h00, 0, 0);
      nchk++; if (o_Rd_DV !== 1'b0 || o_Empty !== 1'b1 || o_Byte !== 8'h43)
         begin nfail++; $display("FAIL basic_end rddv=%b empty=%b byte=%h exp 0/1/43", o_Rd_DV, o_Empty, o_Byte); end
   endtask

   task automatic test_full_overflow;
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 1, 8'(i), 0, 0);
         nchk++; if (o_Count !== 5'(i + 1) || o_AFull !== (i + 1 >= 12) || o_Full !== (i + 1 == DEPTH))
            begin nfail++; $display("FAIL fill%0d cnt=%0d afull=%b full=%b exp %0d/%b/%b", i, o_Count, o_AFull, o_Full,
                                     i + 1, (i + 1 >= 12), (i + 1 == DEPTH)); end
      end
      step(0, 1, 8'hFF, 0, 0);
      nchk++; if (o_Overflow !== 1'b1 || o_Count !== 5'd16 || o_Full !== 1'b1)
         begin nfail++; $display("FAIL ovf_drop ovf=%b cnt=%0d full=%b exp 1/16/1", o_Overflow, o_Count, o_Full); end
   endtask

   task automatic test_ovf_clear;
      step(0, 0, 8'h00, 0, 1);
      nchk++; if (o_Overflow !== 1'b0) begin nfail++; $display("FAIL ovf_clr got=%b exp=0", o_Overflow); end
      step(0, 1, 8'hEE, 0, 1);
      nchk++; if (o_Overflow !== 1'b1) begin nfail++; $display("FAIL ovf_set_wins got=%b exp=1", o_Overflow); end
      step(0, 0, 8'h00, 0, 1);
      nchk++; if (o_Overflow !== 1'b0 || o_Count !== 5'd16) begin nfail++; $display("FAIL ovf_reclr ovf=%b cnt=%0d exp 0/16", o_Overflow, o_Count); end
   endtask

   task automatic test_passthrough;
      step(0, 1, 8'hAA, 1, 0);
      nchk++; if (o_Count !== 5'd16 || o_Rd_DV !== 1'b1 || o_Byte !== 8'h00 || o_Overflow !== 1'b0)
         begin nfail++; $display("FAIL pass cnt=%0d rddv=%b byte=%h ovf=%b exp 16/1/00/0", o_Count, o_Rd_DV, o_Byte, o_Overflow); end
      for (int i = 1; i <= DEPTH; i++) begin
         step(0, 0, 8'h00, 1, 0);
         nchk++; if (o_Rd_DV !== 1'b1 || o_Byte !== ((i == DEPTH) ? 8'hAA : 8'(i)) || o_Byte !== exp_byte)
            begin nfail++; $display("FAIL drain%0d rddv=%b byte=%h exp 1/%h", i, o_Rd_DV, o_Byte, (i == DEPTH) ? 8'hAA : 8'(i)); end
      end
      step(0, 0, 8'h00, 0, 0);
      nchk++; if (o_Empty !== 1'b1 || o_Rd_DV !== 1'b0) begin nfail++; $display("FAIL drain_end empty=%b rddv=%b exp 1/0", o_Empty, o_Rd_DV); end
   endtask

   task automatic test_wrap_random;
      logic [7:0] sent[$];
      int written = 0;
      int got = 0;
      int cyc = 0;
      logic dv, rd;
      logic [7:0] b;
      while ((written < 40 || q.size() > 0) && cyc < 600) begin
         cyc++;
         b = 8'($urandom);
         if (written >= 40) begin dv = 0; rd = 1; end
         else begin
            dv = (q.size() < 5) || ((q.size() < 10) && ($urandom_range(0, 1) == 1));
            rd = (q.size() > 5) && ($urandom_range(0, 2) != 0);
         end
         if (dv) begin sent.push_back(b); written++; end
         step(0, dv, b, rd, 0);
         nchk++; if (o_Count !== 5'(q.size()) || o_Rd_DV !== exp_rd_dv || o_Overflow !== 1'b0)
            begin nfail++; $display("FAIL wrap_cyc%0d cnt=%0d rddv=%b ovf=%b exp %0d/%b/0", cyc, o_Count, o_Rd_DV, o_Overflow, q.size(), exp_rd_dv); end
         if (o_Rd_DV === 1'b1) begin
            got++;
            nchk++; if (sent.size() == 0 || o_Byte !== sent[0])
               begin nfail++; $display("FAIL wrap_data%0d got=%h exp=%h", got, o_Byte, (sent.size() > 0) ? sent[0] : 8'h00); end
            if (sent.size() > 0) void'(sent.pop_front());
         end
      end
      nchk++; if (got != 40) begin nfail++; $display("FAIL wrap_total got=%0d exp=40", got); end
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 4; i++) step(0, 1, 8'h60 + 8'(i), 0, 0);
      step(0, 0, 8'h00, 1, 0);
      step(1, 1, 8'h77, 1, 0);
      nchk++; if (o_Count !== 5'd0 || o_Empty !== 1'b1 || o_Rd_DV !== 1'b0 || o_Byte !== 8'h00)
         begin nfail++; $display("FAIL mid_reset cnt=%0d empty=%b rddv=%b byte=%h exp 0/1/0/00", o_Count, o_Empty, o_Rd_DV, o_Byte); end
      step(0, 1, 8'h5A, 1, 0);
      nchk++; if (o_Count !== 5'd1 || o_Rd_DV !== 1'b0 || o_Byte !== 8'h00)
         begin nfail++; $display("FAIL empty_rw cnt=%0d rddv=%b byte=%h exp 1/0/00", o_Count, o_Rd_DV, o_Byte); end
      step(0, 0, 8'h00, 1, 0);
      nchk++; if (o_Rd_DV !== 1'b1 || o_Byte !== 8'h5A || o_Empty !== 1'b1)
         begin nfail++; $display("FAIL post_reset_read rddv=%b byte=%h empty=%b exp 1/5a/1", o_Rd_DV, o_Byte, o_Empty); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full_overflow();
      test_ovf_clear();
      test_passthrough();
      test_wrap_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end
endmodule
